des_lfsr_keygen: RTL and testbench

//  LFSR-based round-key generator feeding the DES round datapath and control FSM.
//  - Seeds a Fibonacci LFSR from the master key; expands ROUNDS subkeys, one per cycle.
//  - Stores them in a register file and reports keys_ready.
//  - Serves subkey[] by round index; order is reversed for decrypt.
//  - Handshake: the FSM holds load_k high until keys_ready; this block drives keys_ready.

---
 rtl/des_lfsr_keygen.sv | 98 +++++++++
 tb/tb_des_lfsr_keygen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/des_lfsr_keygen.sv
// LFSR round-key generator: one subkey per cycle, keys_ready ROUNDS cycles after load accept; key_update aborts or invalidates.
// Optional KEYGEN_SEED_GUARD_EN substitutes SEED_CONST for an all-zero key to avoid the LFSR lock-up state.
module des_lfsr_keygen #(
  parameter int              KEY_W      = 64,
  parameter int              SUBKEY_W   = 48,
  parameter int              ROUNDS     = 8,
  parameter int              RCNT_W     = 3,
  parameter int              STEPS      = 4,
  parameter logic [KEY_W-1:0] TAPS       = 64'hD800_0000_0000_0000,
  parameter logic [KEY_W-1:0] SEED_CONST = 64'h0123_4567_89AB_CDEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_k,
  input  logic                key_update,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                enc_dec,
  input  logic [RCNT_W-1:0]   round_cnt,
  output logic                keys_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                kg_busy
);

  typedef enum logic [1:0] {IDLE, GEN, READY} state_t;

  state_t               state;
  logic [KEY_W-1:0]     lfsr;
  logic [KEY_W-1:0]     lfsr_nxt;
  logic [SUBKEY_W-1:0]  store [ROUNDS];
  logic [RCNT_W-1:0]    idx;
  logic [RCNT_W-1:0]    rd_idx;

  // STEPS Fibonacci shifts unrolled into one cycle
  always_comb begin
    lfsr_nxt = lfsr;
    for (int s = 0; s < STEPS; s++) begin
      lfsr_nxt = {lfsr_nxt[KEY_W-2:0], ^(lfsr_nxt & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= '0;
      idx        <= '0;
      keys_ready <= 1'b0;
      kg_busy    <= 1'b0;
      for (int i = 0; i < ROUNDS; i++) store[i] <= '0;
    end else if (key_update) begin
      // Invalidate only; stored keys stay but are masked by keys_ready
      state      <= IDLE;
      keys_ready <= 1'b0;
      kg_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_k) begin
`ifdef KEYGEN_SEED_GUARD_EN
            lfsr <= (key_in == '0) ? SEED_CONST : key_in;
`else
            lfsr <= key_in;
`endif
            idx     <= '0;
            kg_busy <= 1'b1;
            state   <= GEN;
          end
        end
        GEN: begin
          lfsr       <= lfsr_nxt;
          store[idx] <= lfsr_nxt[SUBKEY_W-1:0];
          idx        <= idx + 1'b1;
          if (idx == RCNT_W'(ROUNDS - 1)) begin
            kg_busy    <= 1'b0;
            keys_ready <= 1'b1;
            state      <= READY;
          end
        end
        READY: begin
          keys_ready <= 1'b1;
          kg_busy    <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          keys_ready <= 1'b0;
          kg_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Decrypt walks the schedule backwards
  always_comb begin
    rd_idx = enc_dec ? round_cnt : (RCNT_W'(ROUNDS - 1) - round_cnt);
    subkey = '0;
    if (keys_ready && (32'(round_cnt) < ROUNDS)) subkey = store[rd_idx];
  end

endmodule

// File: tb/tb_des_lfsr_keygen.sv
// Directed bench for des_lfsr_keygen: latency, enc/dec ordering, abort, zero key, reset mid-generation, READY hold.
module tb_des_lfsr_keygen;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_k;
  logic        key_update;
  logic [63:0] key_in;
  logic        enc_dec;
  logic [2:0]  round_cnt;
  logic        keys_ready;
  logic [47:0] subkey;
  logic        kg_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  des_lfsr_keygen dut (
    .clk        (clk),
    .rst        (rst),
    .load_k     (load_k),
    .key_update (key_update),
    .key_in     (key_in),
    .enc_dec    (enc_dec),
    .round_cnt  (round_cnt),
    .keys_ready (keys_ready),
    .subkey     (subkey),
    .kg_busy    (kg_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (keys_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {63'd0, keys_ready}, 64'd1);
  endtask

  // key_in=1: taps never see a set bit, so round k holds 1 << (4k+4)
  task automatic check_key1_sched(input string tag);
    logic [47:0] e;
    for (int k = 0; k < 8; k++) begin
      enc_dec = 1'b1; round_cnt = 3'(k); #1;
      e = 48'h1 << (4 * k + 4);
      check({tag, "_enc"}, {16'd0, subkey}, {16'd0, e});
      enc_dec = 1'b0; #1;
      e = 48'h1 << (4 * (7 - k) + 4);
      check({tag, "_dec"}, {16'd0, subkey}, {16'd0, e});
    end
  endtask

`ifdef KEYGEN_SEED_GUARD_EN
  function automatic logic [63:0] adv4(input logic [63:0] v);
    logic [63:0] t;
    logic [63:0] taps;
    t = v;
    taps = 64'hD800_0000_0000_0000;
    for (int s = 0; s < 4; s++) t = {t[62:0], ^(t & taps)};
    return t;
  endfunction
`endif

  initial begin
    rst = 1'b1; load_k = 1'b0; key_update = 1'b0; key_in = '0;
    enc_dec = 1'b1; round_cnt = '0;
    tick(); tick();
    check("rst_ready", {63'd0, keys_ready}, 64'd0);
    check("rst_busy", {63'd0, kg_busy}, 64'd0);
    check("rst_subkey", {16'd0, subkey}, 64'd0);
    rst = 1'b0;
    tick();

    // Load key 1, one-cycle request; exact 8-cycle latency
    key_in = 64'h1; load_k = 1'b1;
    tick();
    load_k = 1'b0; key_in = 64'hDEAD_BEEF_0000_0000;
    check("gen_busy", {63'd0, kg_busy}, 64'd1);
    for (int i = 0; i < 7; i++) tick();
    check("lat_not_yet", {63'd0, keys_ready}, 64'd0);
    check("lat_busy_still", {63'd0, kg_busy}, 64'd1);
    tick();
    check("lat_ready", {63'd0, keys_ready}, 64'd1);
    check("lat_busy_done", {63'd0, kg_busy}, 64'd0);
    check_key1_sched("key1");

    // load_k held in READY with a different key must not regenerate
    key_in = 64'hFFFF_FFFF_FFFF_FFFF; load_k = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_busy", {63'd0, kg_busy}, 64'd0);
    end
    load_k = 1'b0;
    check("hold_ready", {63'd0, keys_ready}, 64'd1);
    check_key1_sched("hold");

    // key_update invalidates; subkey masked
    key_update = 1'b1; tick(); key_update = 1'b0;
    check("upd_ready", {63'd0, keys_ready}, 64'd0);
    enc_dec = 1'b1; round_cnt = 3'd3; #1;
    check("upd_subkey", {16'd0, subkey}, 64'd0);

    // Abort 3 cycles into GEN
    key_in = 64'h1; load_k = 1'b1; tick(); load_k = 1'b0;
    tick(); tick();
    key_update = 1'b1; tick(); key_update = 1'b0;
    check("abort_busy", {63'd0, kg_busy}, 64'd0);
    check("abort_ready", {63'd0, keys_ready}, 64'd0);

    // Simultaneous load and key_update in IDLE: load deferred
    load_k = 1'b1; key_update = 1'b1; tick(); key_update = 1'b0;
    check("prio_idle", {63'd0, kg_busy}, 64'd0);
    tick(); load_k = 1'b0;
    check("prio_accept", {63'd0, kg_busy}, 64'd1);
    wait_ready("reload_ready", 20);
    check_key1_sched("reload");

    // All-zero key
    key_update = 1'b1; tick(); key_update = 1'b0;
    key_in = 64'h0; load_k = 1'b1; tick(); load_k = 1'b0;
    wait_ready("zero_ready", 20);
    begin
      logic [63:0] m;
      m = 64'h0123_4567_89AB_CDEF;
      for (int k = 0; k < 8; k++) begin
        enc_dec = 1'b1; round_cnt = 3'(k); #1;
`ifdef KEYGEN_SEED_GUARD_EN
        m = adv4(m);
        check("zero_seed", {16'd0, subkey}, {16'd0, m[47:0]});
`else
        check("zero_key", {16'd0, subkey}, {m[63:0] & 64'd0});
`endif
      end
    end

    // Reset at GEN idx=5
    key_update = 1'b1; tick(); key_update = 1'b0;
    key_in = 64'h1; load_k = 1'b1; tick(); load_k = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", {63'd0, kg_busy}, 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_ready", {63'd0, keys_ready}, 64'd0);
    check("mid_rst_busy", {63'd0, kg_busy}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      enc_dec = 1'b1; round_cnt = 3'(k); #1;
      check("mid_rst_sub_e", {16'd0, subkey}, 64'd0);
      enc_dec = 1'b0; #1;
      check("mid_rst_sub_d", {16'd0, subkey}, 64'd0);
    end
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_idle", {62'd0, kg_busy, keys_ready}, 64'd0);

    // Generation after reset works normally
    key_in = 64'h1; load_k = 1'b1; tick(); load_k = 1'b0;
    wait_ready("post_rst_ready", 20);
    check_key1_sched("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
